// File: rtl/dmem_access_if.sv
// Bus bundle for dmem_access: EX-side request, memory port and WB-side result.
// The slave modport is the dmem_access view; master is the surrounding pipeline/memory view.
interface dmem_access_if;
    localparam int unsigned XLEN = 64;
    localparam int unsigned RD_W = 5;
    localparam int unsigned SZ_W = 2;

    // EX side
    logic            in_valid;
    logic            in_ready;
    logic            is_load;
    logic            is_store;
    logic [SZ_W-1:0] xfer_size;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] dAddr9Extended;
    logic [XLEN-1:0] store_data;

    // memory side
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [SZ_W-1:0] mem_size;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;

    // WB side
    logic            out_valid;
    logic            out_ready;
    logic [RD_W-1:0] out_rd;
    logic [XLEN-1:0] out_data;
    logic            out_wr_en;
    logic            out_fault;

    modport slave (
        input  in_valid, is_load, is_store, xfer_size, rd, base, dAddr9Extended, store_data,
        output in_ready,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_size,
        input  mem_ack, mem_rdata,
        output out_valid, out_rd, out_data, out_wr_en, out_fault,
        input  out_ready
    );

    modport master (
        output in_valid, is_load, is_store, xfer_size, rd, base, dAddr9Extended, store_data,
        input  in_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_size,
        output mem_ack, mem_rdata,
        input  out_valid, out_rd, out_data, out_wr_en, out_fault,
        output out_ready
    );
endinterface

// File: rtl/dmem_access.sv
// Data-memory access stage: one load/store at a time through IDLE -> REQ -> RESP.
// Optional DMEM_MISALIGN_CHECK_EN faults misaligned accesses instead of issuing them.
module dmem_access (
    input  logic         clk,
    input  logic         reset,
    dmem_access_if.slave bus
);
    localparam int unsigned XLEN = 64;
    localparam int unsigned RD_W = 5;
    localparam int unsigned SZ_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e          state_q,     state_d;
    logic            in_ready_q,  in_ready_d;
    logic            mem_req_q,   mem_req_d;
    logic            mem_we_q,    mem_we_d;
    logic [XLEN-1:0] mem_addr_q,  mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [SZ_W-1:0] mem_size_q,  mem_size_d;
    logic            out_valid_q, out_valid_d;
    logic [RD_W-1:0] out_rd_q,    out_rd_d;
    logic [XLEN-1:0] out_data_q,  out_data_d;
    logic            out_wr_en_q, out_wr_en_d;
    logic            out_fault_q, out_fault_d;

    logic [XLEN-1:0] addr_c;
    logic [XLEN-1:0] load_ext_c;
    logic            accept_c;
    logic            is_mem_c;
    logic            misalign_c;

    // Effective address wraps modulo 2^64.
    assign addr_c   = bus.base + bus.dAddr9Extended;
    assign accept_c = bus.in_valid & in_ready_q;
    assign is_mem_c = bus.is_load | bus.is_store;

`ifdef DMEM_MISALIGN_CHECK_EN
    always_comb begin
        misalign_c = 1'b0;
        case (bus.xfer_size)
            2'd1:    misalign_c = addr_c[0];
            2'd2:    misalign_c = |addr_c[1:0];
            2'd3:    misalign_c = |addr_c[2:0];
            default: misalign_c = 1'b0;
        endcase
    end
`else
    assign misalign_c = 1'b0;
`endif

    // Zero-extend the returned read data to the transfer width latched at accept.
    always_comb begin
        load_ext_c = bus.mem_rdata;
        case (mem_size_q)
            2'd0:    load_ext_c = XLEN'(bus.mem_rdata[7:0]);
            2'd1:    load_ext_c = XLEN'(bus.mem_rdata[15:0]);
            2'd2:    load_ext_c = XLEN'(bus.mem_rdata[31:0]);
            default: load_ext_c = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_size_d  = mem_size_q;
        out_valid_d = out_valid_q;
        out_rd_d    = out_rd_q;
        out_data_d  = out_data_q;
        out_wr_en_d = out_wr_en_q;
        out_fault_d = out_fault_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    out_rd_d    = bus.rd;
                    mem_size_d  = bus.xfer_size;
                    mem_addr_d  = addr_c;
                    mem_wdata_d = bus.store_data;
                    mem_we_d    = bus.is_store;
                    if (is_mem_c && !misalign_c) begin
                        state_d     = REQ;
                        mem_req_d   = 1'b1;
                        out_fault_d = 1'b0;
                    end else begin
                        // Address-only op or faulted access: result is the address itself.
                        state_d     = RESP;
                        out_valid_d = 1'b1;
                        out_data_d  = addr_c;
                        out_wr_en_d = 1'b0;
                        out_fault_d = is_mem_c;
                    end
                end
            end
            REQ: begin
                if (bus.mem_ack) begin
                    state_d     = RESP;
                    mem_req_d   = 1'b0;
                    out_valid_d = 1'b1;
                    out_wr_en_d = ~mem_we_q;
                    out_data_d  = mem_we_q ? mem_addr_q : load_ext_c;
                end
            end
            RESP: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_req_d   = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_size_q  <= '0;
            out_valid_q <= 1'b0;
            out_rd_q    <= '0;
            out_data_q  <= '0;
            out_wr_en_q <= 1'b0;
            out_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_size_q  <= mem_size_d;
            out_valid_q <= out_valid_d;
            out_rd_q    <= out_rd_d;
            out_data_q  <= out_data_d;
            out_wr_en_q <= out_wr_en_d;
            out_fault_q <= out_fault_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_size  = mem_size_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_rd    = out_rd_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_wr_en = out_wr_en_q;
    assign bus.out_fault = out_fault_q;

endmodule
